bitwise_arbiter: RTL and testbench

Round-robin arbiter that shares one N-bit bitwise logic datapath (AND/OR/XOR/NOR) between two requesters. Each requester presents operands and an opcode with a valid/ready handshake. The arbiter grants one request per cycle, computes the result through the shared datapath and holds it in a single registered output slot with requester ID until the consumer accepts it. It sits between the Lab 4 ALU front-end ports and the per-bit gate datapath.

---
 rtl/bitwise_pkg.sv | 16 +
 rtl/bitwise_unit.sv | 38 +++
 rtl/bitwise_arbiter.sv | 119 +++++++++++
 tb/tb_bitwise_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bitwise_pkg.sv
// Shared types and constants for the two-requester bitwise arbiter.
package bitwise_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned ID_W    = 1;
    localparam int unsigned OP_W    = 2;

    // Per-bit logic function applied across the whole operand width.
    typedef enum logic [OP_W-1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_t;

endpackage

// File: rtl/bitwise_unit.sv
// Shared combinational datapath: one gate per bit per function, then a 4:1 select.
module bitwise_unit
    import bitwise_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  op_t          op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

    wire [N-1:0] and_y;
    wire [N-1:0] or_y;
    wire [N-1:0] xor_y;
    wire [N-1:0] nor_y;

    // Per-bit gate instances for every supported function.
    for (genvar i = 0; i < int'(N); i++) begin : g_bit
        and u_and (and_y[i], a[i], b[i]);
        or  u_or  (or_y[i],  a[i], b[i]);
        xor u_xor (xor_y[i], a[i], b[i]);
        nor u_nor (nor_y[i], a[i], b[i]);
    end

    // Pick the requested function.
    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = and_y;
            OP_OR:   y = or_y;
            OP_XOR:  y = xor_y;
            OP_NOR:  y = nor_y;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_arbiter.sv
// Round-robin arbiter sharing one bitwise datapath between two requesters,
// with a single registered result slot tagged by requester id.
module bitwise_arbiter
    import bitwise_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         in0_valid,
    input  op_t          in0_op,
    input  logic [N-1:0] in0_a,
    input  logic [N-1:0] in0_b,
    output logic         in0_ready,

    input  logic         in1_valid,
    input  op_t          in1_op,
    input  logic [N-1:0] in1_a,
    input  logic [N-1:0] in1_b,
    output logic         in1_ready,

    output logic         out_valid,
    output logic [N-1:0] out_result,
    output logic [ID_W-1:0] out_id,
    input  logic         out_ready
);

    logic            out_valid_q,  out_valid_d;
    logic [N-1:0]    out_result_q, out_result_d;
    logic [ID_W-1:0] out_id_q,     out_id_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;

    logic            slot_free;
    logic            gnt0;
    logic            gnt1;
    logic            xfer;
    op_t             sel_op;
    logic [N-1:0]    sel_a;
    logic [N-1:0]    sel_b;
    logic [N-1:0]    unit_y;

    assign slot_free = !out_valid_q || out_ready;

    // Grant: single requester wins outright; a tie goes to the one not served last.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && slot_free) begin
            if (in0_valid && in1_valid) begin
                if (last_grant_q == ID_W'(0)) gnt1 = 1'b1;
                else                          gnt0 = 1'b1;
            end else if (in0_valid) begin
                gnt0 = 1'b1;
            end else if (in1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign in0_ready = gnt0;
    assign in1_ready = gnt1;
    assign xfer      = gnt0 || gnt1;

    // Steer the granted requester's operands into the shared datapath.
    always_comb begin
        sel_op = in0_op;
        sel_a  = in0_a;
        sel_b  = in0_b;
        if (gnt1) begin
            sel_op = in1_op;
            sel_a  = in1_a;
            sel_b  = in1_b;
        end
    end

    bitwise_unit #(.N(N)) u_unit (
        .op (sel_op),
        .a  (sel_a),
        .b  (sel_b),
        .y  (unit_y)
    );

    // Slot next-state: load on transfer, drain when consumed, otherwise hold.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_id_d     = out_id_q;
        last_grant_d = last_grant_q;
        if (xfer) begin
            out_valid_d  = 1'b1;
            out_result_d = unit_y;
            out_id_d     = ID_W'(gnt1);
            last_grant_d = ID_W'(gnt1);
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    // Slot and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_id_q     <= '0;
            last_grant_q <= ID_W'(1);
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_id_q     <= out_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_id     = out_id_q;

endmodule

// File: tb/tb_bitwise_arbiter.sv
// Self-checking bench for bitwise_arbiter: directed scenarios plus random traffic
// compared against a transaction-level reference model.
module tb_bitwise_arbiter;
    import bitwise_pkg::*;

    localparam int unsigned N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in0_valid, in1_valid;
    op_t          in0_op, in1_op;
    logic [N-1:0] in0_a, in0_b, in1_a, in1_b;
    logic         in0_ready, in1_ready;
    logic         out_valid;
    logic [N-1:0] out_result;
    logic [0:0]   out_id;
    logic         out_ready;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic         m_valid  = 1'b0;
    logic [N-1:0] m_result = '0;
    logic         m_id     = 1'b0;
    logic         m_last   = 1'b1;
    logic         m_g0, m_g1;

    always #5 clk = ~clk;

    bitwise_arbiter #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in0_valid  (in0_valid),
        .in0_op     (in0_op),
        .in0_a      (in0_a),
        .in0_b      (in0_b),
        .in0_ready  (in0_ready),
        .in1_valid  (in1_valid),
        .in1_op     (in1_op),
        .in1_a      (in1_a),
        .in1_b      (in1_b),
        .in1_ready  (in1_ready),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_id     (out_id),
        .out_ready  (out_ready)
    );

    function automatic logic [N-1:0] ref_op(op_t op, logic [N-1:0] a, logic [N-1:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check readies before the edge, advance the model, check the slot after.
    task automatic cycle();
        logic free;
        #3;
        free = !m_valid || out_ready;
        m_g0 = 1'b0;
        m_g1 = 1'b0;
        if (!rst && free) begin
            if (in0_valid && in1_valid) begin
                if (m_last) m_g0 = 1'b1;
                else        m_g1 = 1'b1;
            end else if (in0_valid) m_g0 = 1'b1;
            else if (in1_valid)     m_g1 = 1'b1;
        end
        check("in0_ready", N'(in0_ready), N'(m_g0));
        check("in1_ready", N'(in1_ready), N'(m_g1));
        @(posedge clk);
        if (rst) begin
            m_valid  = 1'b0;
            m_result = '0;
            m_id     = 1'b0;
            m_last   = 1'b1;
        end else if (m_g0 || m_g1) begin
            m_valid  = 1'b1;
            m_id     = m_g1;
            m_last   = m_g1;
            m_result = m_g1 ? ref_op(in1_op, in1_a, in1_b) : ref_op(in0_op, in0_a, in0_b);
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check("out_valid", N'(out_valid), N'(m_valid));
        if (m_valid || rst) begin
            check("out_result", out_result, m_result);
            check("out_id", N'(out_id), N'(m_id));
        end
    endtask

    initial begin
        logic pend0, pend1;
        rst = 1'b1;
        in0_valid = 1'b1; in0_op = OP_AND; in0_a = '0; in0_b = '0;
        in1_valid = 1'b0; in1_op = OP_AND; in1_a = '0; in1_b = '0;
        out_ready = 1'b1;

        // Reset holds everything idle even with a request present
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("rst_ready0", N'(in0_ready), '0);
            check("rst_valid", N'(out_valid), '0);
            check("rst_result", out_result, '0);
            check("rst_id", N'(out_id), '0);
        end
        rst = 1'b0;
        in0_valid = 1'b0;
        cycle();

        // Round-robin: both continuously valid, expect 0,1,0,1
        in0_valid = 1'b1; in0_op = OP_AND; in0_a = 32'hFFFF_0000; in0_b = 32'h0F0F_0F0F;
        in1_valid = 1'b1; in1_op = OP_XOR; in1_a = 32'hAAAA_AAAA; in1_b = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("rr_id", N'(out_id), N'(i % 2));
            check("rr_result", out_result, (i % 2 == 0) ? 32'h0F0F_0000 : 32'h5555_5555);
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        cycle();

        // Single OR from requester 0
        in0_valid = 1'b1; in0_op = OP_OR; in0_a = 32'hF0F0_0000; in0_b = 32'h0000_0F0F;
        cycle();
        check("or_valid", N'(out_valid), N'(1));
        check("or_result", out_result, 32'hF0F0_0F0F);
        check("or_id", N'(out_id), '0);
        in0_valid = 1'b0;

        // Backpressure: slot frozen, requester 1 stalled
        out_ready = 1'b0;
        in1_valid = 1'b1; in1_op = OP_AND; in1_a = 32'h1234_5678; in1_b = 32'hFF00_FF00;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_ready1", N'(in1_ready), '0);
            check("bp_result", out_result, 32'hF0F0_0F0F);
            check("bp_id", N'(out_id), '0);
        end
        out_ready = 1'b1;
        cycle();
        check("bp_release_valid", N'(out_valid), N'(1));
        check("bp_release_result", out_result, 32'h1200_5600);
        check("bp_release_id", N'(out_id), N'(1));

        // NOR boundaries from requester 1
        in1_op = OP_NOR; in1_a = '0; in1_b = '0;
        cycle();
        check("nor_zero", out_result, 32'hFFFF_FFFF);
        check("nor_zero_id", N'(out_id), N'(1));
        in1_a = 32'hFFFF_FFFF; in1_b = '0;
        cycle();
        check("nor_ones", out_result, 32'h0000_0000);
        in1_valid = 1'b0;

        // Reset mid-operation after requester 0 was last served
        in0_valid = 1'b1; in0_op = OP_XOR; in0_a = 32'h0000_FFFF; in0_b = 32'h00FF_00FF;
        cycle();
        in0_valid = 1'b0; out_ready = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        check("midrst_valid", N'(out_valid), '0);
        rst = 1'b0; out_ready = 1'b1;
        in0_valid = 1'b1; in1_valid = 1'b1;
        in0_op = OP_OR;  in0_a = 32'h0000_0001; in0_b = 32'h8000_0000;
        in1_op = OP_AND; in1_a = 32'hFFFF_FFFF; in1_b = 32'h0000_0000;
        cycle();
        check("midrst_tie_id", N'(out_id), '0);
        check("midrst_tie_result", out_result, 32'h8000_0001);
        in0_valid = 1'b0; in1_valid = 1'b0;
        cycle();

        // Random traffic; requests are held stable until accepted
        pend0 = 1'b0; pend1 = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!pend0) begin
                in0_valid = ($urandom_range(0, 3) != 0);
                in0_op    = op_t'($urandom_range(0, 3));
                in0_a     = ($urandom_range(0, 7) == 0) ? '1 : N'($urandom);
                in0_b     = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            end
            if (!pend1) begin
                in1_valid = ($urandom_range(0, 3) != 0);
                in1_op    = op_t'($urandom_range(0, 3));
                in1_a     = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
                in1_b     = ($urandom_range(0, 7) == 0) ? '1 : N'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            cycle();
            pend0 = in0_valid && !m_g0;
            pend1 = in1_valid && !m_g1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
